// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-port memory between the fetch stage (instruction reads)
// and the memory stage (data loads/stores). One request is captured at a
// time and carried over a req/gnt/rvalid handshake to the memory. The
// response is routed back to whichever stage owns the transaction. Data
// requests win by default. A streak counter limits how many data grants in a
// row can be taken while a fetch is waiting, so fetch always makes progress.
//
// Optional feature macro: UMA_TIMEOUT_EN
//   When defined, a transaction that spends TIMEOUT_CYCLES cycles in REQ+WAIT
//   is aborted. The owner receives rvalid with zero data and err pulses.
//   When undefined, err is tied low and the arbiter waits indefinitely.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   if_req/if_addr                   fetch read request
//   if_gnt/if_rvalid/if_rdata        fetch capture strobe, response
//   stall_f                          fetch stall (if_req & ~if_rvalid)
//   d_req/d_we/d_addr/d_wdata/d_be   data load/store request
//   d_gnt/d_rvalid/d_rdata           data capture strobe, response/ack
//   stall_m                          memory-stage stall (d_req & ~d_rvalid)
//   mem_req/we/addr/wdata/be         registered memory request
//   mem_gnt/mem_rvalid/mem_rdata     memory accept and response
//   busy                             transaction in flight
//   err                              timeout abort pulse
// ---------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int MAX_DATA_STREAK = 3,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        stall_f,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        stall_m,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    // Catch meaningless configurations at elaboration time.
    if (MAX_DATA_STREAK < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("unified_mem_arbiter: MAX_DATA_STREAK and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

    state_t          state;
    owner_t          owner;
    logic [SW-1:0]   streak;
    logic            pick_d;
    logic            pick_i;
    logic            done;
    logic            abort;

`ifdef UMA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;

    // Abort fires in the TIMEOUT_CYCLES-th cycle spent in REQ+WAIT.
    assign abort = ~rst & (state != IDLE) & (tmo_cnt == TMO_LAST);

    // Cycle counter for the transaction in flight; held at zero while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == IDLE || abort) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    assign abort = 1'b0;
`endif

    // Request selection and response routing. Strobes are forced low during
    // reset so the pipeline never sees a stray grant or response.
    always_comb begin
        pick_d    = d_req & (~if_req | (streak < STREAK_MAX));
        pick_i    = if_req & ~pick_d;
        if_gnt    = ~rst & (state == IDLE) & pick_i;
        d_gnt     = ~rst & (state == IDLE) & pick_d;
        done      = (~rst & (state == WAIT) & mem_rvalid) | abort;
        if_rvalid = done & (owner == OWN_IF);
        d_rvalid  = done & (owner == OWN_D);
        // An aborted transaction returns zero data even if memory answers late.
        if_rdata  = (if_rvalid & ~abort) ? mem_rdata : 32'h0;
        d_rdata   = (d_rvalid & ~abort) ? mem_rdata : 32'h0;
        stall_f   = if_req & ~if_rvalid;
        stall_m   = d_req & ~d_rvalid;
        busy      = (state != IDLE);
        err       = abort;
    end

    // Transaction FSM with registered memory-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_NONE;
            streak    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_be;
                        owner     <= OWN_D;
                        state     <= REQ;
                        // Streak only counts data wins that made a fetch wait.
                        if (!if_req) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + SW'(1);
                        end
                    end else if (pick_i) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= 32'h0;
                        mem_be    <= 4'hF;
                        owner     <= OWN_IF;
                        state     <= REQ;
                        streak    <= '0;
                    end
                end
                REQ: begin
                    if (abort) begin
                        mem_req <= 1'b0;
                        owner   <= OWN_NONE;
                        state   <= IDLE;
                    end else if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort || mem_rvalid) begin
                        owner <= OWN_NONE;
                        state <= IDLE;
                    end
                end
                default: begin
                    owner <= OWN_NONE;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Directed scenarios for the arbiter followed by a randomized phase. In the
// randomized phase the bench plays both pipeline stages and the memory, and
// predicts every output from a transaction-level model of the arbitration
// rules (one transaction in flight, data preferred, bounded data streak).
// Inputs change just after the falling edge and outputs are sampled 1 ns
// later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_unified_mem_arbiter;

    localparam int MAXS = 2;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        stall_f;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        stall_m;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        err;

    int testCount = 0;
    int failCount = 0;

    unified_mem_arbiter #(
        .MAX_DATA_STREAK(MAXS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .stall_f   (stall_f),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .stall_m   (stall_m),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // One comparison: counted, and reported on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, then settle.
    task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw, input logic [31:0] da,
                                 input logic [31:0] dwd, input logic [3:0] db,
                                 input logic mg, input logic mrv, input logic [31:0] mrd);
        @(negedge clk);
        if_req     = ir;
        if_addr    = ia;
        d_req      = dr;
        d_we       = dw;
        d_addr     = da;
        d_wdata    = dwd;
        d_be       = db;
        mem_gnt    = mg;
        mem_rvalid = mrv;
        mem_rdata  = mrd;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Transaction-level reference model state for the randomized phase.
    logic        mBusy, mAccepted, mOwnD;
    int          mStreak, rvDelay, reqWait;
    logic        mWe;
    logic [31:0] mAddr, mWdata;
    logic [3:0]  mBe;
    logic        ifPend, dPend, dWeR;
    logic [31:0] ifAddrR, dAddrR, dWdataR, rdR;
    logic [3:0]  dBeR;
    logic        mgR, mrvR;
    logic        expPickD, expPickI, expIfRv, expDRv, realResp;
    logic        grantD [6];

    initial begin
        rst = 1'b1;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

        // ---- Reset: registered outputs at reset values, strobes forced low
        applyStimulus(1, 32'h10, 1, 1, 32'h20, 32'h55, 4'hF, 1, 1, 32'hFFFF_FFFF);
        checkOutput("rst_if_gnt", if_gnt, 0);
        checkOutput("rst_d_gnt", d_gnt, 0);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_mem_be", mem_be, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_if_rvalid", if_rvalid, 0);
        checkOutput("rst_d_rvalid", d_rvalid, 0);
        idleCycle();
        rst = 1'b0;
        idleCycle();
        checkOutput("post_rst_busy", busy, 0);

        // ---- Fetch only, minimum turnaround
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("f_gnt_c0", if_gnt, 1);
        checkOutput("f_stall_c0", stall_f, 1);
        checkOutput("f_memreq_c0", mem_req, 0);
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("f_memreq_c1", mem_req, 1);
        checkOutput("f_addr_c1", mem_addr, 32'h0);
        checkOutput("f_we_c1", mem_we, 0);
        checkOutput("f_be_c1", mem_be, 4'hF);
        checkOutput("f_gnt_c1", if_gnt, 0);
        checkOutput("f_stall_c1", stall_f, 1);
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 0, 0, 1, 32'h0050_0093);
        checkOutput("f_rvalid_c2", if_rvalid, 1);
        checkOutput("f_rdata_c2", if_rdata, 32'h0050_0093);
        checkOutput("f_stall_c2", stall_f, 0);
        checkOutput("f_d_rvalid_c2", d_rvalid, 0);
        checkOutput("f_memreq_c2", mem_req, 0);
        idleCycle();
        checkOutput("f_busy_c3", busy, 0);
        checkOutput("f_rdata_idle", if_rdata, 0);

        // ---- Simultaneous fetch and load: data first, then fetch
        applyStimulus(1, 32'h4, 1, 0, 32'h100, 0, 4'hF, 0, 0, 0);
        checkOutput("s_d_gnt", d_gnt, 1);
        checkOutput("s_if_gnt", if_gnt, 0);
        applyStimulus(1, 32'h4, 1, 0, 32'h100, 0, 4'hF, 1, 0, 0);
        checkOutput("s_addr_d", mem_addr, 32'h100);
        checkOutput("s_we_d", mem_we, 0);
        applyStimulus(1, 32'h4, 1, 0, 32'h100, 0, 4'hF, 0, 1, 32'h1111_2222);
        checkOutput("s_d_rvalid", d_rvalid, 1);
        checkOutput("s_d_rdata", d_rdata, 32'h1111_2222);
        checkOutput("s_if_rvalid", if_rvalid, 0);
        checkOutput("s_if_rdata", if_rdata, 0);
        applyStimulus(1, 32'h4, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("s_if_gnt2", if_gnt, 1);
        applyStimulus(1, 32'h4, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("s_addr_i", mem_addr, 32'h4);
        applyStimulus(1, 32'h4, 0, 0, 0, 0, 0, 0, 1, 32'h3333_4444);
        checkOutput("s_if_rvalid2", if_rvalid, 1);
        checkOutput("s_if_rdata2", if_rdata, 32'h3333_4444);

        // ---- Continuous contention with MAX_DATA_STREAK=2: D,D,I,D,D,I
        grantD = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1, 32'h8, 1, 0, 32'h180, 0, 4'hF, 0, 0, 0);
            checkOutput($sformatf("st_d_gnt%0d", k), d_gnt, grantD[k]);
            checkOutput($sformatf("st_if_gnt%0d", k), if_gnt, !grantD[k]);
            applyStimulus(1, 32'h8, 1, 0, 32'h180, 0, 4'hF, 1, 0, 0);
            checkOutput($sformatf("st_addr%0d", k), mem_addr, grantD[k] ? 32'h180 : 32'h8);
            applyStimulus(1, 32'h8, 1, 0, 32'h180, 0, 4'hF, 0, 1, 32'hC0DE_0000 + k);
            checkOutput($sformatf("st_d_rv%0d", k), d_rvalid, grantD[k]);
            checkOutput($sformatf("st_if_rv%0d", k), if_rvalid, !grantD[k]);
        end

        // ---- Store with delayed memory grant
        applyStimulus(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF, 4'b0011, 0, 0, 0);
        checkOutput("w_d_gnt", d_gnt, 1);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF, 4'b0011, k == 4, 0, 0);
            checkOutput($sformatf("w_req%0d", k), mem_req, 1);
            checkOutput($sformatf("w_we%0d", k), mem_we, 1);
            checkOutput($sformatf("w_addr%0d", k), mem_addr, 32'h200);
            checkOutput($sformatf("w_wdata%0d", k), mem_wdata, 32'hDEAD_BEEF);
            checkOutput($sformatf("w_be%0d", k), mem_be, 4'b0011);
            checkOutput($sformatf("w_stall%0d", k), stall_m, 1);
        end
        applyStimulus(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF, 4'b0011, 0, 1, 32'hAAAA_AAAA);
        checkOutput("w_d_rvalid", d_rvalid, 1);
        checkOutput("w_if_rvalid", if_rvalid, 0);
        checkOutput("w_stall_ack", stall_m, 0);
        idleCycle();

        // ---- Reset while waiting for a response
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("r_gnt", if_gnt, 1);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        checkOutput("r_mem_req", mem_req, 0);
        checkOutput("r_mem_addr", mem_addr, 0);
        checkOutput("r_mem_be", mem_be, 0);
        checkOutput("r_busy", busy, 0);
        checkOutput("r_if_gnt", if_gnt, 0);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
        checkOutput("r_rv_in_rst", if_rvalid, 0);
        checkOutput("r_rdata_in_rst", if_rdata, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
        rst = 1'b0;
        #1;
        checkOutput("r_rv_idle", if_rvalid, 0);
        checkOutput("r_drv_idle", d_rvalid, 0);
        checkOutput("r_busy_idle", busy, 0);
        applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("r_regnt", if_gnt, 1);
        applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("r_readdr", mem_addr, 32'h80);
        applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D);
        checkOutput("r_rerv", if_rvalid, 1);
        checkOutput("r_rerdata", if_rdata, 32'h0BAD_F00D);
        idleCycle();

`ifdef UMA_TIMEOUT_EN
        // ---- Memory never grants: abort after TMO cycles in REQ
        applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t_gnt", if_gnt, 1);
        for (int k = 1; k <= TMO; k++) begin
            applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("t_err%0d", k), err, k == TMO);
            checkOutput($sformatf("t_rv%0d", k), if_rvalid, k == TMO);
            checkOutput($sformatf("t_rdata%0d", k), if_rdata, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_0000);
        checkOutput("t_busy_after", busy, 0);
        checkOutput("t_req_after", mem_req, 0);
        checkOutput("t_err_after", err, 0);
        checkOutput("t_late_rv", if_rvalid, 0);
`endif

        // ---- Randomized traffic against the transaction-level model
        mBusy = 0; mAccepted = 0; mOwnD = 0; mStreak = 0; rvDelay = 0; reqWait = 0;
        mWe = 0; mAddr = 0; mWdata = 0; mBe = 0;
        ifPend = 0; dPend = 0; ifAddrR = 0; dAddrR = 0; dWdataR = 0; dBeR = 0; dWeR = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!ifPend && ($urandom % 3 != 0)) begin
                ifPend  = 1;
                ifAddrR = $urandom & 32'hFFFF_FFFC;
            end
            if (!dPend && ($urandom % 3 != 0)) begin
                dPend   = 1;
                dWeR    = $urandom % 2;
                dAddrR  = $urandom & 32'hFFFF_FFFC;
                dWdataR = $urandom;
                dBeR    = $urandom % 16;
            end
            // Memory grants within three REQ cycles so a timeout never fires.
            mgR  = mBusy && !mAccepted && (reqWait >= 2 || ($urandom % 2 == 1));
            mrvR = mAccepted ? (rvDelay == 0) : ($urandom % 8 == 0);
            rdR  = $urandom;
            applyStimulus(ifPend, ifAddrR, dPend, dWeR, dAddrR, dWdataR, dBeR, mgR, mrvR, rdR);

            expPickD = !mBusy && dPend && (!ifPend || mStreak < MAXS);
            expPickI = !mBusy && ifPend && !expPickD;
            realResp = mAccepted && mrvR;
            expIfRv  = realResp && !mOwnD;
            expDRv   = realResp && mOwnD;

            checkOutput("rnd_if_gnt", if_gnt, expPickI);
            checkOutput("rnd_d_gnt", d_gnt, expPickD);
            checkOutput("rnd_if_rvalid", if_rvalid, expIfRv);
            checkOutput("rnd_d_rvalid", d_rvalid, expDRv);
            checkOutput("rnd_if_rdata", if_rdata, expIfRv ? rdR : 32'h0);
            if (!(expDRv && mWe)) checkOutput("rnd_d_rdata", d_rdata, expDRv ? rdR : 32'h0);
            checkOutput("rnd_stall_f", stall_f, ifPend && !expIfRv);
            checkOutput("rnd_stall_m", stall_m, dPend && !expDRv);
            checkOutput("rnd_mem_req", mem_req, mBusy && !mAccepted);
            checkOutput("rnd_busy", busy, mBusy);
            checkOutput("rnd_err", err, 0);
            if (mBusy && !mAccepted) begin
                checkOutput("rnd_mem_addr", mem_addr, mAddr);
                checkOutput("rnd_mem_we", mem_we, mWe);
                checkOutput("rnd_mem_be", mem_be, mBe);
                if (mOwnD) checkOutput("rnd_mem_wdata", mem_wdata, mWdata);
            end

            // Advance the model across the rising edge.
            if (expPickD || expPickI) begin
                mBusy = 1; mAccepted = 0; mOwnD = expPickD; reqWait = 0;
                if (expPickD) begin
                    mWe = dWeR; mAddr = dAddrR; mWdata = dWdataR; mBe = dBeR;
                    mStreak = ifPend ? ((mStreak + 1 > MAXS) ? MAXS : mStreak + 1) : 0;
                end else begin
                    mWe = 0; mAddr = ifAddrR; mBe = 4'hF;
                    mStreak = 0;
                end
            end else if (mBusy && !mAccepted) begin
                if (mgR) begin
                    mAccepted = 1;
                    rvDelay = $urandom % 3;
                end else begin
                    reqWait++;
                end
            end else if (mAccepted) begin
                if (mrvR) begin
                    mBusy = 0;
                    mAccepted = 0;
                end else begin
                    rvDelay--;
                end
            end
            if (expIfRv) ifPend = 0;
            if (expDRv) dPend = 0;
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline core. Captures one request at a time and drives the memory bus through a req/gnt/rvalid handshake. Routes the response back to the owning requester and raises per-stage stall signals until that requester is served. Data has priority, bounded by an anti-starvation counter so fetch always progresses.

Parameters:
MAX_DATA_STREAK, 3, max consecutive data grants while a fetch is pending before fetch is forced to win (>=1)
TIMEOUT_CYCLES, 255, cycles allowed in REQ+WAIT before abort (used only with UMA_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch read request (level)
if_addr  in  32  fetch address
if_gnt  out  1  fetch request captured this cycle
if_rvalid  out  1  fetch data valid (1-cycle pulse)
if_rdata  out  32  fetch data
stall_f  out  1  if_req & ~if_rvalid
d_req  in  1  data request (level)
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data address
d_wdata  in  32  store data
d_be  in  4  store byte enables
d_gnt  out  1  data request captured this cycle
d_rvalid  out  1  load data valid / store ack (1-cycle pulse)
d_rdata  out  32  load data
stall_m  out  1  d_req & ~d_rvalid
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  32  memory address, registered
mem_wdata  out  32  memory write data, registered
mem_be  out  4  memory byte enables, registered
mem_gnt  in  1  memory accepted mem_req this cycle
mem_rvalid  in  1  memory response/ack valid
mem_rdata  in  32  memory read data
busy  out  1  state != IDLE
err  out  1  timeout abort pulse

Behaviour:
- Reset (async, rst=1): state=IDLE, owner=NONE, streak=0, timeout counter=0.
  - Outputs during and after reset: mem_req/mem_we=0, mem_addr/mem_wdata=0, mem_be=0, err=0.
  - Combinational outputs if_gnt, d_gnt, if_rvalid, d_rvalid are forced to 0 while rst=1.
- FSM states: IDLE, REQ, WAIT.
- IDLE selection:
  - pick_d = d_req & (~if_req | streak<MAX_DATA_STREAK)
  - pick_i = if_req & ~pick_d
  - The selected requester's gnt=1 (combinational, same cycle).
  - At the clock edge, the selected request's fields are latched into the mem_* registers and mem_req=1.
  - Fetch capture drives mem_we=0 and mem_be=4'hF.
  - owner is set to the selected requester; state goes to REQ.
- REQ: mem_req and all mem_* fields are held stable until mem_gnt=1. At that edge mem_req clears and state goes to WAIT.
- WAIT: when mem_rvalid=1, the owner's x_rvalid=1 and x_rdata=mem_rdata (combinational, same cycle). At that edge state goes to IDLE and owner to NONE.
- Store completion: stores complete on mem_rvalid (the ack); d_rdata is don't-care for stores.
- Response gating: mem_rvalid is ignored in IDLE and REQ. The non-owner's rvalid is never asserted.
- Requester contract: a requester keeps req high and its fields stable until its rvalid. Its req is ignored outside IDLE. The first IDLE cycle after its rvalid counts as a new request.
- Minimum turnaround (mem_gnt immediate, mem_rvalid 1 cycle after gnt): capture c0, mem_req c1, rvalid c2, next capture c3.
- streak counter:
  - On a data capture with if_req=1: streak+1, saturating at MAX_DATA_STREAK.
  - On a data capture with if_req=0: streak=0.
  - On a fetch capture: streak=0.
  - Width $clog2(MAX_DATA_STREAK+1).
- Unused rdata outputs hold 0 when their rvalid=0.

Optional Feature:
UMA_TIMEOUT_EN
- Defined:
  - The counter increments every cycle in REQ/WAIT and clears on entering IDLE.
  - On reaching TIMEOUT_CYCLES, for one cycle: state goes to IDLE, mem_req=0, err=1, the owner's rvalid=1 with rdata=32'h0. This keeps the pipeline from hanging.
  - A late mem_rvalid for the aborted transaction, arriving in IDLE or REQ, is ignored.
- Undefined: the counter is absent, err is tied 0, and the FSM waits indefinitely.

Test Plan:
- Fetch only: if_addr=0x0, mem_gnt immediate, mem_rvalid=1 with 0x00500093 one cycle later -> if_gnt c0, mem_req c1, if_rvalid with 0x00500093 c2; stall_f=1 c0-c1, 0 c2.
- Simultaneous if_req (0x4) and d_req load (0x100) in IDLE, streak=0 -> d_gnt first, mem_addr=0x100; fetch captured at the first IDLE after d_rvalid, mem_addr=0x4.
- MAX_DATA_STREAK=2, d_req and if_req held continuously -> grant order D,D,I,D,D,I; streak reads 0 after each I.
- Store d_addr=0x200, d_wdata=0xDEADBEEF, d_be=4'b0011, mem_gnt delayed 3 cycles -> mem_we=1 and fields stable for all 4 REQ cycles; d_rvalid on ack; if_rvalid stays 0.
- rst=1 asserted in WAIT, then mem_rvalid pulses -> all outputs at reset values immediately; no x_rvalid; the next request is served normally.
- UMA_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, memory never grants -> at 8 cycles err=1 and if_rvalid=1 with rdata=0; back in IDLE the following cycle.
